// File: rtl/sseg_display_bank.sv
// sseg_display_bank: registered multi-digit seven-segment driver with value capture,
// per-digit enable/blink, leading-zero blanking and an unlock banner sequence.
`default_nettype none

module sseg_display_bank #(
  parameter int NUM_DIGITS    = 6,
  parameter int BLINK_DIV     = 25000000,
  parameter int BANNER_CYCLES = 50000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] i_value,
  input  logic                    i_load,
  input  logic                    i_unlock,
  input  logic [NUM_DIGITS-1:0]   i_digit_en,
  input  logic [NUM_DIGITS-1:0]   i_blink_mask,
  input  logic                    i_lz_suppress,
  output logic [7*NUM_DIGITS-1:0] seg
);

  localparam int BLW = $clog2(BLINK_DIV);
  localparam int BNW = $clog2(BANNER_CYCLES + 1);
  localparam logic [BLW-1:0] BLINK_LAST  = BLW'(BLINK_DIV - 1);
  localparam logic [BNW-1:0] BANNER_LAST = BNW'(BANNER_CYCLES - 1);

  localparam logic [6:0] G_BLANK = 7'h7F;
  localparam logic [6:0] G_DASH  = 7'h3F;
  localparam logic [6:0] G_O     = 7'h40;
  localparam logic [6:0] G_P     = 7'h0C;
  localparam logic [6:0] G_E     = 7'h06;
  localparam logic [6:0] G_N     = 7'h2B;

  typedef enum logic [1:0] {
    SHOW     = 2'd0,
    BANNER   = 2'd1,
    UNLOCKED = 2'd2
  } state_t;

  state_t                    state;
  logic [4*NUM_DIGITS-1:0]   value;
  logic                      unlock_q;
  logic [BNW-1:0]            banner_cnt;
  logic [BLW-1:0]            blink_cnt;
  logic                      phase;
  logic                      rise;
  logic                      fall;
  logic                      zero_above;
  logic [6:0]                glyph;
  logic [7*NUM_DIGITS-1:0]   seg_next;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h40;
      4'h1: hex_glyph = 7'h79;
      4'h2: hex_glyph = 7'h24;
      4'h3: hex_glyph = 7'h30;
      4'h4: hex_glyph = 7'h19;
      4'h5: hex_glyph = 7'h12;
      4'h6: hex_glyph = 7'h02;
      4'h7: hex_glyph = 7'h78;
      4'h8: hex_glyph = 7'h00;
      4'h9: hex_glyph = 7'h10;
      4'hA: hex_glyph = 7'h08;
      4'hB: hex_glyph = 7'h03;
      4'hC: hex_glyph = 7'h46;
      4'hD: hex_glyph = 7'h21;
      4'hE: hex_glyph = 7'h06;
      default: hex_glyph = 7'h0E;
    endcase
  endfunction

  always_comb begin
    rise       = i_unlock & ~unlock_q;
    fall       = ~i_unlock & unlock_q;
    zero_above = 1'b1;
    glyph      = G_BLANK;
    seg_next   = {NUM_DIGITS{G_BLANK}};
    // Walk from the most significant digit so zero_above tracks "all nibbles k..top are 0".
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (value[4*k +: 4] == 4'd0);
      glyph      = G_BLANK;
      case (state)
        BANNER: begin
          case (k)
            0:       glyph = G_N;
            1:       glyph = G_E;
            2:       glyph = G_P;
            3:       glyph = G_O;
            default: glyph = G_BLANK;
          endcase
        end
        UNLOCKED: glyph = G_DASH;
        default: begin
          if (!i_digit_en[k])
            glyph = G_BLANK;
          else if (i_blink_mask[k] && !phase)
            glyph = G_BLANK;
          else if (i_lz_suppress && (k != 0) && zero_above)
            glyph = G_BLANK;
          else
            glyph = hex_glyph(value[4*k +: 4]);
        end
      endcase
      seg_next[7*k +: 7] = glyph;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      value      <= '0;
      unlock_q   <= 1'b0;
      state      <= SHOW;
      banner_cnt <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b1;
      seg        <= {NUM_DIGITS{G_BLANK}};
    end else begin
      seg      <= seg_next;
      unlock_q <= i_unlock;
      if (i_load)
        value <= i_value;

      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + BLW'(1);
      end

      // A relock wins over banner expiry arriving in the same cycle.
      case (state)
        SHOW: begin
          if (rise) begin
            state      <= BANNER;
            banner_cnt <= '0;
          end
        end
        BANNER: begin
          banner_cnt <= banner_cnt + BNW'(1);
          if (fall)
            state <= SHOW;
          else if (banner_cnt == BANNER_LAST)
            state <= UNLOCKED;
        end
        UNLOCKED: begin
          if (fall)
            state <= SHOW;
        end
        default: state <= SHOW;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sseg_display_bank.sv
// tb_sseg_display_bank: directed stimulus with a cycle-level display model and literal spot checks.
`default_nettype none

module tb_sseg_display_bank;

  localparam int ND = 6;
  localparam int BD = 4;
  localparam int BC = 5;
  localparam int SW = 7 * ND;

  logic          clk = 1'b0;
  logic          rst;
  logic [4*ND-1:0] i_value;
  logic          i_load;
  logic          i_unlock;
  logic [ND-1:0] i_digit_en;
  logic [ND-1:0] i_blink_mask;
  logic          i_lz_suppress;
  logic [SW-1:0] seg;

  int n_cmp = 0;
  int n_bad = 0;

  sseg_display_bank #(
    .NUM_DIGITS   (ND),
    .BLINK_DIV    (BD),
    .BANNER_CYCLES(BC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_value      (i_value),
    .i_load       (i_load),
    .i_unlock     (i_unlock),
    .i_digit_en   (i_digit_en),
    .i_blink_mask (i_blink_mask),
    .i_lz_suppress(i_lz_suppress),
    .seg          (seg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] pack6(input logic [6:0] d5, d4, d3, d2, d1, d0);
    return {d5, d4, d3, d2, d1, d0};
  endfunction

  // Behavioural model: mode 0 = showing value, 1 = banner, 2 = dashes.
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] ban_tab [4]  = '{7'h2B, 7'h06, 7'h0C, 7'h40};

  logic [SW-1:0]   exp_seg;
  logic [4*ND-1:0] mval;
  int              mode, belap, cyc;
  logic            mprev;
  bit              mvalid = 0;

  always @(posedge clk) begin
    if (!rst) begin
      exp_seg = {ND{7'h7F}};
      mval = '0; mode = 0; belap = 0; cyc = 0; mprev = 1'b0;
    end else begin
      for (int k = 0; k < ND; k++) begin
        logic [6:0] d;
        logic [4*ND-1:0] upper;
        bit visible;
        upper   = mval >> (4 * k);
        visible = ((cyc / BD) % 2) == 0;
        if (mode == 2) d = 7'h3F;
        else if (mode == 1) d = (k < 4) ? ban_tab[k] : 7'h7F;
        else if (!i_digit_en[k]) d = 7'h7F;
        else if (i_blink_mask[k] && !visible) d = 7'h7F;
        else if (i_lz_suppress && k != 0 && upper == 0) d = 7'h7F;
        else d = hex_tab[upper[3:0]];
        exp_seg[7*k +: 7] = d;
      end
      if (mode == 1) begin
        belap++;
        if (!i_unlock && mprev) mode = 0;
        else if (belap == BC) mode = 2;
      end else if (mode == 2) begin
        if (!i_unlock && mprev) mode = 0;
      end else if (i_unlock && !mprev) begin
        mode = 1; belap = 0;
      end
      if (i_load) mval = i_value;
      mprev = i_unlock;
      cyc++;
    end
    mvalid = 1;
  end

  always @(negedge clk) begin
    if (mvalid) chk("model", 64'(seg), 64'(exp_seg));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic load_val(input logic [4*ND-1:0] v);
    i_value = v;
    i_load  = 1'b1;
    tick(1);
    i_load  = 1'b0;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int blanks;
    rst = 1'b0; i_value = '0; i_load = 1'b0; i_unlock = 1'b0;
    i_digit_en = '1; i_blink_mask = '0; i_lz_suppress = 1'b0;
    tick(3);
    chk("reset_blank", 64'(seg), 64'({ND{7'h7F}}));

    rst = 1'b1;
    load_val(24'h0123AF);
    chk("first_load", 64'(seg), 64'(pack6(7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h0E)));

    i_lz_suppress = 1'b1;
    load_val(24'h000050);
    chk("lz_050", 64'(seg), 64'(pack6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h40)));
    load_val(24'h000000);
    chk("lz_zero", 64'(seg), 64'(pack6(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40)));
    i_digit_en = 6'b000000;
    tick(1);
    chk("all_disabled", 64'(seg), 64'({ND{7'h7F}}));
    i_digit_en = '1;
    i_lz_suppress = 1'b0;

    load_val(24'h123456);
    i_digit_en = 6'b101010;
    tick(1);
    chk("digit_en", 64'(seg), 64'(pack6(7'h79, 7'h7F, 7'h30, 7'h7F, 7'h12, 7'h7F)));
    i_digit_en = '1;

    i_blink_mask = 6'b000001;
    blanks = 0;
    for (int i = 0; i < 4 * BD; i++) begin
      tick(1);
      if (seg[6:0] == 7'h7F) blanks++;
      chk("blink_steady", 64'(seg[SW-1:7]), 64'(pack6(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02) >> 7));
    end
    chk("blink_half", 64'(blanks), 64'(2 * BD));
    i_blink_mask = '0;

    i_unlock = 1'b1;
    tick(1);
    for (int i = 0; i < BC; i++) begin
      tick(1);
      chk("banner", 64'(seg), 64'(pack6(7'h7F, 7'h7F, 7'h40, 7'h0C, 7'h06, 7'h2B)));
    end
    tick(1);
    chk("dashes", 64'(seg), 64'({ND{7'h3F}}));
    tick(3);
    chk("dashes_hold", 64'(seg), 64'({ND{7'h3F}}));
    i_unlock = 1'b0;
    tick(2);
    chk("relock", 64'(seg), 64'(pack6(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02)));

    i_unlock = 1'b1;
    tick(BC);
    i_unlock = 1'b0;
    tick(2);
    chk("fall_vs_expiry", 64'(seg), 64'(pack6(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02)));
    tick(3);
    chk("fall_vs_expiry_hold", 64'(seg), 64'(pack6(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02)));

    i_unlock = 1'b1;
    tick(3);
    rst = 1'b0;
    i_unlock = 1'b0;
    tick(1);
    chk("reset_mid_banner", 64'(seg), 64'({ND{7'h7F}}));
    rst = 1'b1;
    tick(2);
    chk("after_reset_show", 64'(seg), 64'({ND{7'h40}}));
    tick(BC + 2);
    chk("no_residual_banner", 64'(seg), 64'({ND{7'h40}}));

    i_unlock = 1'b1;
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(2);
    chk("unlock_at_release", 64'(seg), 64'(pack6(7'h7F, 7'h7F, 7'h40, 7'h0C, 7'h06, 7'h2B)));
    i_unlock = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
